// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the fifo_sync_param codebase slice.
//   clog2()       : constant ceiling-log2, usable in parameter expressions
//   ptr_width()   : pointer width for a given depth (log2 of depth)
//   cnt_width()   : occupancy-count width (one extra bit so count can hold DEPTH)
//   AF_RESET_MARGIN / AE_RESET_DEFAULT : reset-time threshold pair; the
//     almost_full default sits AF_RESET_MARGIN entries below DEPTH.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int AF_RESET_MARGIN  = 3;
  localparam int AE_RESET_DEFAULT = 3;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// WIDTH x DEPTH dual-port register array for the synchronous FIFO.
// Ports:
//   clk      : write clock (rising edge)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, asynchronous (combinational from raddr_i)
// ---------------------------------------------------------------------------
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; a cleared FIFO is defined by its
  // pointers and count, so resetting every word would only cost flops and
  // prevent mapping onto RAM-style resources.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parameterised single-clock FIFO with runtime-programmable almost-flags,
// one-cycle overflow/underflow pulses and sticky error flags.
//
// Optional feature: define FIFO_FWFT_EN for first-word-fall-through reads
// (data_out always shows the head entry, valid = !empty). Without the macro
// the FIFO uses standard latency-1 reads (valid pulses for one cycle).
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   wr_en, data_in           : write request and data
//   rd_en                    : read request
//   data_out, valid          : read data and its qualifier
//   full, almost_full        : occupancy flags (count == DEPTH, count >= af)
//   empty, almost_empty      : occupancy flags (count == 0,     count <= ae)
//   overflow, underflow      : one-cycle pulses for rejected write / read
//   ovf_sticky, udf_sticky   : latched error flags, cleared by clr_err
//   clr_err                  : clears both sticky flags
//   thr_wr, af_thr, ae_thr   : load new almost_full / almost_empty thresholds
//   count                    : registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AF_DEFAULT = DEPTH - AF_RESET_MARGIN,
  parameter int AE_DEFAULT = AE_RESET_DEFAULT,
  parameter int CW         = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic             ovf_sticky,
  output logic             udf_sticky,
  input  logic             clr_err,
  input  logic             thr_wr,
  input  logic [CW-1:0]    af_thr,
  input  logic [CW-1:0]    ae_thr,
  output logic [CW-1:0]    count
);

  localparam int AW = ptr_width(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [AW-1:0]    wptr_q,       wptr_d;
  logic [AW-1:0]    rptr_q,       rptr_d;
  logic [CW-1:0]    count_q,      count_d;
  logic [CW-1:0]    af_thr_q,     af_thr_d;
  logic [CW-1:0]    ae_thr_q,     ae_thr_d;
  logic             overflow_q,   overflow_d;
  logic             underflow_q,  underflow_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             udf_sticky_q, udf_sticky_d;

  logic             full_w;
  logic             empty_w;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_rej;
  logic             rd_rej;
  logic [WIDTH-1:0] mem_rdata;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (data_in),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  // -------------------------------------------------------------------------
  // Flags decoded from the registered count, so they move together with it.
  // -------------------------------------------------------------------------
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A write while full is still taken when a read frees the head slot in the
  // same cycle: the async read port returns the old head before the write
  // lands at the edge, and wptr == rptr when full.
  assign wr_acc = wr_en && (!full_w || rd_en);
  assign rd_acc = rd_en && !empty_w;
  assign wr_rej = wr_en && !wr_acc;
  assign rd_rej = rd_en && empty_w;

  // NOTE: next-state logic lives in always_comb with blocking assignments and
  // a default for every signal up front, so no path can infer a latch.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    af_thr_d     = af_thr_q;
    ae_thr_d     = ae_thr_q;
    overflow_d   = wr_rej;
    underflow_d  = rd_rej;
    ovf_sticky_d = ovf_sticky_q;
    udf_sticky_d = udf_sticky_q;

    // Pointers wrap naturally: DEPTH is a power of two and AW = log2(DEPTH).
    if (wr_acc) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + AW'(1);
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end

    // A new error in the same cycle as clr_err wins, so no event is lost.
    if (clr_err) begin
      ovf_sticky_d = 1'b0;
      udf_sticky_d = 1'b0;
    end
    if (wr_rej) begin
      ovf_sticky_d = 1'b1;
    end
    if (rd_rej) begin
      udf_sticky_d = 1'b1;
    end

    // Thresholds are taken verbatim; out-of-range values simply pin the flag.
    if (thr_wr) begin
      af_thr_d = af_thr;
      ae_thr_d = ae_thr;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      af_thr_q     <= CW'(AF_DEFAULT);
      ae_thr_q     <= CW'(AE_DEFAULT);
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      af_thr_q     <= af_thr_d;
      ae_thr_q     <= ae_thr_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read data path
  // -------------------------------------------------------------------------
`ifdef FIFO_FWFT_EN
  // Head entry is always visible; forced to zero while empty so the output
  // never exposes stale or uninitialised storage.
  assign data_out = empty_w ? '0 : mem_rdata;
  assign valid    = !empty_w;
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q,    valid_d;

  // The popped word is captured and held until the next accepted read.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = rd_acc;
    if (rd_acc) begin
      data_out_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= af_thr_q);
  assign almost_empty = (count_q <= ae_thr_q);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign ovf_sticky   = ovf_sticky_q;
  assign udf_sticky   = udf_sticky_q;
  assign count        = count_q;

endmodule : fifo_sync_param

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
// Self-checking bench for fifo_sync_param (default parameters). A queue-based
// reference model predicts every output after each clock edge. Honours
// FIFO_FWFT_EN when the RTL is built with it.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [W-1:0]  data_in;
  logic          rd_en;
  logic [W-1:0]  data_out;
  logic          valid;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
  logic          ovf_sticky;
  logic          udf_sticky;
  logic          clr_err;
  logic          thr_wr;
  logic [CW-1:0] af_thr;
  logic [CW-1:0] ae_thr;
  logic [CW-1:0] count;

  fifo_sync_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid        (valid),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .ovf_sticky   (ovf_sticky),
    .udf_sticky   (udf_sticky),
    .clr_err      (clr_err),
    .thr_wr       (thr_wr),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] m_q [$];
  int           m_af;
  int           m_ae;
  bit           m_ovf, m_udf, m_ovf_s, m_udf_s, m_valid_std;
  logic [W-1:0] m_dout_std;

  task automatic model_reset();
    m_q.delete();
    m_af        = D - 3;
    m_ae        = 3;
    m_ovf       = 0;
    m_udf       = 0;
    m_ovf_s     = 0;
    m_udf_s     = 0;
    m_valid_std = 0;
    m_dout_std  = '0;
  endtask

  task automatic model_edge(input bit wr, input logic [W-1:0] din, input bit rd,
                            input bit clr, input bit thr,
                            input int af, input int ae);
    int  n;
    bit  wr_ok, rd_ok;
    n     = m_q.size();
    wr_ok = wr && ((n < D) || rd);
    rd_ok = rd && (n > 0);
    m_ovf = wr && !wr_ok;
    m_udf = rd && (n == 0);
    m_valid_std = rd_ok;
    if (rd_ok) m_dout_std = m_q.pop_front();
    if (wr_ok) m_q.push_back(din);
    if (m_ovf) m_ovf_s = 1; else if (clr) m_ovf_s = 0;
    if (m_udf) m_udf_s = 1; else if (clr) m_udf_s = 0;
    if (thr) begin
      m_af = af;
      m_ae = ae;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int           n;
    bit           e_valid;
    logic [W-1:0] e_dout;
    n = m_q.size();
`ifdef FIFO_FWFT_EN
    e_valid = (n != 0);
    e_dout  = (n != 0) ? m_q[0] : '0;
`else
    e_valid = m_valid_std;
    e_dout  = m_dout_std;
`endif
    check({ctx, ":count"},        32'(count),        32'(n));
    check({ctx, ":full"},         32'(full),         32'(n == D));
    check({ctx, ":empty"},        32'(empty),        32'(n == 0));
    check({ctx, ":almost_full"},  32'(almost_full),  32'(n >= m_af));
    check({ctx, ":almost_empty"}, 32'(almost_empty), 32'(n <= m_ae));
    check({ctx, ":valid"},        32'(valid),        32'(e_valid));
    check({ctx, ":data_out"},     32'(data_out),     32'(e_dout));
    check({ctx, ":overflow"},     32'(overflow),     32'(m_ovf));
    check({ctx, ":underflow"},    32'(underflow),    32'(m_udf));
    check({ctx, ":ovf_sticky"},   32'(ovf_sticky),   32'(m_ovf_s));
    check({ctx, ":udf_sticky"},   32'(udf_sticky),   32'(m_udf_s));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at
  // the next falling edge.
  task automatic step(input string ctx, input bit wr = 0, input logic [W-1:0] din = '0,
                      input bit rd = 0, input bit clr = 0, input bit thr = 0,
                      input int af = 0, input int ae = 0);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    clr_err = clr;
    thr_wr  = thr;
    af_thr  = CW'(af);
    ae_thr  = CW'(ae);
    @(posedge clk);
    model_edge(wr, din, rd, clr, thr, af, ae);
    @(negedge clk);
    wr_en   = 0;
    rd_en   = 0;
    clr_err = 0;
    thr_wr  = 0;
    check_all(ctx);
  endtask

  initial begin
    rst_n   = 0;
    wr_en   = 0;
    data_in = '0;
    rd_en   = 0;
    clr_err = 0;
    thr_wr  = 0;
    af_thr  = '0;
    ae_thr  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset_empty", 32'(empty), 32'd1);
    rst_n = 1;

    // Fill with 1..16; flags tracked by the model each cycle.
    for (int i = 1; i <= D; i++) begin
      step("fill", 1, W'(i), 0);
      if (i == 12) check("af_below_13", 32'(almost_full), 32'd0);
      if (i == 13) check("af_at_13", 32'(almost_full), 32'd1);
    end
    check("fill_full", 32'(full), 32'd1);

    step("ovf", 1, 8'hEE, 0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    step("ovf_clear_pulse");
    check("ovf_pulse_gone", 32'(overflow), 32'd0);
    check("ovf_sticky_held", 32'(ovf_sticky), 32'd1);

    // Drain 1..16.
    for (int i = 1; i <= D; i++) begin
      step("drain", 0, '0, 1);
`ifndef FIFO_FWFT_EN
      check("drain_data", 32'(data_out), 32'(i));
      check("drain_valid", 32'(valid), 32'd1);
`endif
      if (i == 13) check("ae_at_3", 32'(almost_empty), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);

    step("udf", 0, '0, 1);
    check("udf_pulse", 32'(underflow), 32'd1);
    check("udf_valid", 32'(valid), 32'd0);

    // Simultaneous write+read while empty.
    step("wr_rd_empty", 1, 8'h55, 1);
    check("wre_udf", 32'(underflow), 32'd1);
    check("wre_count", 32'(count), 32'd1);

    // Refill, then simultaneous write+read while full: oldest (0x55) read.
    for (int i = 0; i < D - 1; i++) step("refill", 1, W'(8'h60 + i), 0);
    step("wr_rd_full", 1, 8'hAA, 1);
    check("wrf_count", 32'(count), 32'd16);
    check("wrf_ovf", 32'(overflow), 32'd0);
`ifndef FIFO_FWFT_EN
    check("wrf_oldest", 32'(data_out), 32'h55);
`endif
    for (int i = 0; i < D; i++) step("drain2", 0, '0, 1);
`ifndef FIFO_FWFT_EN
    check("drain2_last_aa", 32'(data_out), 32'hAA);
`endif

    // Programmed thresholds.
    step("thr", 0, '0, 0, 0, 1, 8, 2);
    for (int i = 1; i <= 8; i++) begin
      step("thr_fill", 1, W'(8'h30 + i), 0);
      if (i == 7) check("af8_below", 32'(almost_full), 32'd0);
      if (i == 8) check("af8_at", 32'(almost_full), 32'd1);
    end
    step("clr", 0, '0, 0, 1);
    check("clr_ovf", 32'(ovf_sticky), 32'd0);
    check("clr_udf", 32'(udf_sticky), 32'd0);

    // Reset mid-fill at count 7, asserted between edges.
    step("pre_rst", 0, '0, 1);
    check("pre_rst_count", 32'(count), 32'd7);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1;
    step("post_rst_wr", 1, 8'hC3, 0);
    step("post_rst_rd", 0, '0, 1);
`ifndef FIFO_FWFT_EN
    check("post_rst_data", 32'(data_out), 32'hC3);
`endif

`ifdef FIFO_FWFT_EN
    step("fwft_w1", 1, 8'h11, 0);
    step("fwft_w2", 1, 8'h22, 0);
    check("fwft_head", 32'(data_out), 32'h11);
    check("fwft_valid", 32'(valid), 32'd1);
    step("fwft_pop", 0, '0, 1);
    check("fwft_next", 32'(data_out), 32'h22);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit wr, rd, clr, thr;
      wr  = ($urandom_range(99) < 55);
      rd  = ($urandom_range(99) < 50);
      clr = ($urandom_range(99) < 5);
      thr = ($urandom_range(99) < 3);
      step("rand", wr, W'($urandom), rd, clr, thr,
           int'($urandom_range(D)), int'($urandom_range(D)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_sync_param
